// File: rtl/ifu_fetch_if.sv
// Bundle between the fetch stage and its neighbours: redirect input, instruction memory port, decode handshake.
// The fetch unit connects through the master modport; memory, decode and redirect sources use the slave modport.
interface ifu_fetch_if;
    logic        redirect_vld_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvld_i;
    logic [31:0] imem_rdata_i;
    logic        inst_vld_o;
    logic [31:0] inst_data_o;
    logic [31:0] inst_pc_o;
    logic        inst_rdy_i;

    modport master (
        input  redirect_vld_i, redirect_pc_i, imem_gnt_i, imem_rvld_i, imem_rdata_i, inst_rdy_i,
        output imem_req_o, imem_addr_o, inst_vld_o, inst_data_o, inst_pc_o
    );

    modport slave (
        output redirect_vld_i, redirect_pc_i, imem_gnt_i, imem_rvld_i, imem_rdata_i, inst_rdy_i,
        input  imem_req_o, imem_addr_o, inst_vld_o, inst_data_o, inst_pc_o
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues word fetches, queues returned words in order for decode,
// and flushes/discards in-flight responses on a redirect.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic         clk,
    input logic         rst_n,
    ifu_fetch_if.master bus
);
    localparam int             CW      = $clog2(DEPTH + 1);
    localparam int             IW      = $clog2(DEPTH);
    localparam logic [CW:0]    DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t        r_state, w_stateNext;
    logic [31:0]   r_pc, r_respPc;
    logic [CW-1:0] r_outstanding, r_count, r_dropCnt;
    logic [31:0]   r_qData [DEPTH];
    logic [31:0]   r_qPc   [DEPTH];

    logic          w_req, w_grant, w_pop, w_push, w_drop, w_redirect;
    logic [CW-1:0] w_outNext, w_dropNext, w_pushIdxFull;
    logic [31:0]   w_redirectPc;

    assign w_redirect    = bus.redirect_vld_i;
    assign w_redirectPc  = {bus.redirect_pc_i[31:2], 2'b00};
    assign w_grant       = w_req & bus.imem_gnt_i;
    assign w_pop         = (r_count != '0) & bus.inst_rdy_i;
    assign w_drop        = bus.imem_rvld_i & (w_redirect | (r_dropCnt != '0));
    assign w_push        = bus.imem_rvld_i & ~w_drop;
    assign w_outNext     = r_outstanding + CW'(w_grant) - CW'(bus.imem_rvld_i);
    assign w_pushIdxFull = w_pop ? (r_count - CW'(1)) : r_count;

    // A redirect re-arms the drop counter with whatever is still in flight after this cycle's response.
    always_comb begin
        w_dropNext = r_dropCnt;
        if (w_redirect) begin
            w_dropNext = w_outNext;
        end else if (bus.imem_rvld_i && (r_dropCnt != '0)) begin
            w_dropNext = r_dropCnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    w_stateNext = RUN;
            RUN:     if (w_redirect && (w_dropNext != '0)) w_stateNext = FLUSH;
            FLUSH:   if (w_dropNext == '0) w_stateNext = RUN;
            default: w_stateNext = IDLE;
        endcase
    end

    // Credit check counts queued and in-flight words so a returning response always has a free slot.
    always_comb begin
        w_req = 1'b0;
        if ((r_state == RUN) && !w_redirect &&
            (({1'b0, r_outstanding} + {1'b0, r_count}) < DEPTH_C)) begin
            w_req = 1'b1;
        end
    end

    assign bus.imem_req_o  = w_req;
    assign bus.imem_addr_o = r_pc;
    assign bus.inst_vld_o  = (r_count != '0);
    assign bus.inst_data_o = r_qData[0];
    assign bus.inst_pc_o   = r_qPc[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_respPc      <= RESET_PC;
            r_outstanding <= '0;
            r_count       <= '0;
            r_dropCnt     <= '0;
        end else begin
            r_outstanding <= w_outNext;
            r_dropCnt     <= w_dropNext;
            if (w_redirect) begin
                r_pc     <= w_redirectPc;
                r_respPc <= w_redirectPc;
                r_count  <= '0;
            end else begin
                if (w_grant) r_pc <= r_pc + 32'd4;
                if (w_push)  r_respPc <= r_respPc + 32'd4;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // Shift queue with the head at entry 0; the last entry is not shifted out so an empty queue keeps showing it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_qData[i] <= '0;
                r_qPc[i]   <= '0;
            end
        end else if (!w_redirect) begin
            if (w_pop && (r_count > CW'(1))) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    r_qData[i] <= r_qData[i + 1];
                    r_qPc[i]   <= r_qPc[i + 1];
                end
            end
            if (w_push) begin
                r_qData[w_pushIdxFull[IW-1:0]] <= bus.imem_rdata_i;
                r_qPc[w_pushIdxFull[IW-1:0]]   <= r_respPc;
            end
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a latency-configurable in-order memory plus one task per scenario.
module tb_ifu_fetch;
    localparam logic [31:0] MAGIC = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   memLat = 1;

    logic [31:0] pendAddr[$];
    int          pendDue[$];
    logic [31:0] grantLog[$];
    logic [31:0] instPcLog[$];
    logic [31:0] instDataLog[$];

    ifu_fetch_if bus();

    ifu_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model answers in grant order, memLat cycles after the grant; it also logs grants and decode transfers.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            pendAddr.delete();
            pendDue.delete();
        end else begin
            if (bus.imem_req_o && bus.imem_gnt_i) begin
                pendAddr.push_back(bus.imem_addr_o);
                pendDue.push_back(cyc + memLat - 1);
                grantLog.push_back(bus.imem_addr_o);
            end
            if (bus.inst_vld_o && bus.inst_rdy_i) begin
                instPcLog.push_back(bus.inst_pc_o);
                instDataLog.push_back(bus.inst_data_o);
            end
        end
        #1;
        if (rst_n && (pendAddr.size() != 0) && (pendDue[0] <= cyc)) begin
            bus.imem_rvld_i  = 1'b1;
            bus.imem_rdata_i = pendAddr[0] ^ MAGIC;
            void'(pendAddr.pop_front());
            void'(pendDue.pop_front());
        end else begin
            bus.imem_rvld_i  = 1'b0;
            bus.imem_rdata_i = '0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearLogs();
        grantLog.delete();
        instPcLog.delete();
        instDataLog.delete();
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.redirect_vld_i = 1'b0;
        bus.redirect_pc_i  = '0;
        tick(2);
        clearLogs();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.imem_gnt_i = 1'b1;
        bus.inst_rdy_i = 1'b1;
        memLat = 1;
        rst_n = 1'b0;
        tick(2);
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", bus.imem_req_o); end
        checks++; if (bus.imem_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 00000000", bus.imem_addr_o); end
        checks++; if (bus.inst_vld_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld: got %b expected 0", bus.inst_vld_o); end
        checks++; if (bus.inst_data_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00000000", bus.inst_data_o); end
        checks++; if (bus.inst_pc_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 00000000", bus.inst_pc_o); end
        clearLogs();
        rst_n = 1'b1;
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL idle_bubble_req: got %b expected 0", bus.imem_req_o); end
    endtask

    task automatic test_fetch_stream();
        tick(1);
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=00000000", bus.imem_req_o, bus.imem_addr_o); end
        tick(1);
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h4) begin errors++; $display("[TB] FAIL stream_second_req: got req=%b addr=%h expected req=1 addr=00000004", bus.imem_req_o, bus.imem_addr_o); end
        checks++; if (bus.inst_vld_o !== 1'b0) begin errors++; $display("[TB] FAIL stream_vld_early: got %b expected 0", bus.inst_vld_o); end
        tick(1);
        checks++; if (bus.inst_vld_o !== 1'b1 || bus.inst_pc_o !== 32'h0 || bus.inst_data_o !== MAGIC) begin errors++; $display("[TB] FAIL stream_first_inst: got vld=%b pc=%h data=%h expected vld=1 pc=00000000 data=%h", bus.inst_vld_o, bus.inst_pc_o, bus.inst_data_o, MAGIC); end
        tick(12);
        checks++; if (grantLog.size() < 4) begin errors++; $display("[TB] FAIL stream_grant_count: got %0d expected at least 4", grantLog.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (grantLog[i] !== 32'(4 * i)) begin errors++; $display("[TB] FAIL stream_grant_addr[%0d]: got %h expected %h", i, grantLog[i], 32'(4 * i)); end
            end
        end
        checks++; if (instPcLog.size() < 3) begin errors++; $display("[TB] FAIL stream_inst_count: got %0d expected at least 3", instPcLog.size()); end
        else begin
            checks++; if (instPcLog[1] !== 32'h4 || instPcLog[2] !== 32'h8) begin errors++; $display("[TB] FAIL stream_inst_pc: got %h,%h expected 00000004,00000008", instPcLog[1], instPcLog[2]); end
            checks++; if (instDataLog[2] !== (MAGIC ^ 32'h8)) begin errors++; $display("[TB] FAIL stream_inst_data: got %h expected %h", instDataLog[2], MAGIC ^ 32'h8); end
        end
    endtask

    task automatic test_backpressure();
        bus.imem_gnt_i = 1'b1;
        bus.inst_rdy_i = 1'b0;
        memLat = 1;
        applyReset();
        tick(8);
        checks++; if (grantLog.size() != 2) begin errors++; $display("[TB] FAIL bp_grant_count: got %0d expected 2", grantLog.size()); end
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_stalled: got %b expected 0", bus.imem_req_o); end
        checks++; if (bus.inst_vld_o !== 1'b1 || bus.inst_pc_o !== 32'h0 || bus.inst_data_o !== MAGIC) begin errors++; $display("[TB] FAIL bp_head_held: got vld=%b pc=%h data=%h expected vld=1 pc=00000000 data=%h", bus.inst_vld_o, bus.inst_pc_o, bus.inst_data_o, MAGIC); end
        bus.inst_rdy_i = 1'b1;
        tick(1);
        checks++; if (bus.inst_vld_o !== 1'b1 || bus.inst_pc_o !== 32'h4) begin errors++; $display("[TB] FAIL bp_second_head: got vld=%b pc=%h expected vld=1 pc=00000004", bus.inst_vld_o, bus.inst_pc_o); end
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h8) begin errors++; $display("[TB] FAIL bp_resume_req: got req=%b addr=%h expected req=1 addr=00000008", bus.imem_req_o, bus.imem_addr_o); end
        tick(8);
        checks++; if (instPcLog.size() < 3) begin errors++; $display("[TB] FAIL bp_inst_count: got %0d expected at least 3", instPcLog.size()); end
        else begin
            checks++; if (instPcLog[0] !== 32'h0 || instPcLog[1] !== 32'h4 || instPcLog[2] !== 32'h8) begin errors++; $display("[TB] FAIL bp_inst_order: got %h,%h,%h expected 00000000,00000004,00000008", instPcLog[0], instPcLog[1], instPcLog[2]); end
        end
    endtask

    task automatic test_redirect_flush();
        bus.imem_gnt_i = 1'b1;
        bus.inst_rdy_i = 1'b1;
        memLat = 3;
        applyReset();
        tick(3);
        checks++; if (bus.imem_req_o !== 1'b0 || grantLog.size() != 2) begin errors++; $display("[TB] FAIL flush_two_outstanding: got req=%b grants=%0d expected req=0 grants=2", bus.imem_req_o, grantLog.size()); end
        bus.redirect_vld_i = 1'b1;
        bus.redirect_pc_i  = 32'h100;
        tick(1);
        bus.redirect_vld_i = 1'b0;
        #1;
        checks++; if (bus.imem_req_o !== 1'b0 || bus.inst_vld_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_cycle1: got req=%b vld=%b expected req=0 vld=0", bus.imem_req_o, bus.inst_vld_o); end
        tick(1);
        checks++; if (bus.imem_req_o !== 1'b0 || bus.inst_vld_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_cycle2: got req=%b vld=%b expected req=0 vld=0", bus.imem_req_o, bus.inst_vld_o); end
        tick(1);
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin errors++; $display("[TB] FAIL flush_resume: got req=%b addr=%h expected req=1 addr=00000100", bus.imem_req_o, bus.imem_addr_o); end
        tick(10);
        checks++; if (instPcLog.size() < 1) begin errors++; $display("[TB] FAIL flush_inst_count: got %0d expected at least 1", instPcLog.size()); end
        else begin
            checks++; if (instPcLog[0] !== 32'h100 || instDataLog[0] !== (MAGIC ^ 32'h100)) begin errors++; $display("[TB] FAIL flush_first_inst: got pc=%h data=%h expected pc=00000100 data=%h", instPcLog[0], instDataLog[0], MAGIC ^ 32'h100); end
        end
    endtask

    task automatic test_redirect_collide();
        bus.imem_gnt_i = 1'b1;
        bus.inst_rdy_i = 1'b1;
        memLat = 1;
        applyReset();
        tick(3);
        checks++; if (bus.inst_vld_o !== 1'b1 || bus.inst_pc_o !== 32'h0 || bus.imem_rvld_i !== 1'b1) begin errors++; $display("[TB] FAIL collide_setup: got vld=%b pc=%h rvld=%b expected vld=1 pc=00000000 rvld=1", bus.inst_vld_o, bus.inst_pc_o, bus.imem_rvld_i); end
        bus.redirect_vld_i = 1'b1;
        bus.redirect_pc_i  = 32'h203;
        tick(1);
        bus.redirect_vld_i = 1'b0;
        #1;
        checks++; if (instPcLog.size() != 1) begin errors++; $display("[TB] FAIL collide_handshake: got %0d transfers expected 1", instPcLog.size()); end
        checks++; if (bus.inst_vld_o !== 1'b0) begin errors++; $display("[TB] FAIL collide_queue_cleared: got vld=%b expected 0", bus.inst_vld_o); end
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200) begin errors++; $display("[TB] FAIL collide_next_req: got req=%b addr=%h expected req=1 addr=00000200", bus.imem_req_o, bus.imem_addr_o); end
        tick(8);
        checks++; if (instPcLog.size() < 2) begin errors++; $display("[TB] FAIL collide_inst_count: got %0d expected at least 2", instPcLog.size()); end
        else begin
            checks++; if (instPcLog[1] !== 32'h200 || instDataLog[1] !== (MAGIC ^ 32'h200)) begin errors++; $display("[TB] FAIL collide_after_redirect: got pc=%h data=%h expected pc=00000200 data=%h", instPcLog[1], instDataLog[1], MAGIC ^ 32'h200); end
        end
    endtask

    task automatic test_wrap();
        bus.imem_gnt_i = 1'b0;
        bus.inst_rdy_i = 1'b1;
        memLat = 1;
        applyReset();
        tick(1);
        bus.redirect_vld_i = 1'b1;
        bus.redirect_pc_i  = 32'hFFFF_FFF8;
        #1;
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL wrap_req_masked: got %b expected 0", bus.imem_req_o); end
        tick(1);
        bus.redirect_vld_i = 1'b0;
        bus.imem_gnt_i     = 1'b1;
        #1;
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL wrap_first_req: got req=%b addr=%h expected req=1 addr=fffffff8", bus.imem_req_o, bus.imem_addr_o); end
        tick(10);
        checks++; if (grantLog.size() < 3) begin errors++; $display("[TB] FAIL wrap_grant_count: got %0d expected at least 3", grantLog.size()); end
        else begin
            checks++; if (grantLog[0] !== 32'hFFFF_FFF8 || grantLog[1] !== 32'hFFFF_FFFC || grantLog[2] !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addrs: got %h,%h,%h expected fffffff8,fffffffc,00000000", grantLog[0], grantLog[1], grantLog[2]); end
        end
        checks++; if (instPcLog.size() < 3) begin errors++; $display("[TB] FAIL wrap_inst_count: got %0d expected at least 3", instPcLog.size()); end
        else begin
            checks++; if (instPcLog[2] !== 32'h0 || instDataLog[2] !== MAGIC) begin errors++; $display("[TB] FAIL wrap_inst: got pc=%h data=%h expected pc=00000000 data=%h", instPcLog[2], instDataLog[2], MAGIC); end
        end
    endtask

    task automatic test_reset_full();
        bus.imem_gnt_i = 1'b1;
        bus.inst_rdy_i = 1'b0;
        memLat = 1;
        applyReset();
        tick(8);
        checks++; if (bus.inst_vld_o !== 1'b1 || bus.imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rstfull_setup: got vld=%b req=%b expected vld=1 req=0", bus.inst_vld_o, bus.imem_req_o); end
        rst_n = 1'b0;
        tick(1);
        clearLogs();
        rst_n = 1'b1;
        checks++; if (bus.inst_vld_o !== 1'b0 || bus.imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rstfull_cleared: got vld=%b req=%b expected vld=0 req=0", bus.inst_vld_o, bus.imem_req_o); end
        checks++; if (bus.inst_data_o !== 32'h0 || bus.inst_pc_o !== 32'h0) begin errors++; $display("[TB] FAIL rstfull_outputs: got data=%h pc=%h expected 00000000,00000000", bus.inst_data_o, bus.inst_pc_o); end
        tick(1);
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL rstfull_restart: got req=%b addr=%h expected req=1 addr=00000000", bus.imem_req_o, bus.imem_addr_o); end
        bus.inst_rdy_i = 1'b1;
        tick(8);
        checks++; if (instPcLog.size() < 1) begin errors++; $display("[TB] FAIL rstfull_inst_count: got %0d expected at least 1", instPcLog.size()); end
        else begin
            checks++; if (instPcLog[0] !== 32'h0 || instDataLog[0] !== MAGIC) begin errors++; $display("[TB] FAIL rstfull_first_inst: got pc=%h data=%h expected pc=00000000 data=%h", instPcLog[0], instDataLog[0], MAGIC); end
        end
    endtask

    initial begin
        bus.redirect_vld_i = 1'b0;
        bus.redirect_pc_i  = '0;
        bus.imem_gnt_i     = 1'b0;
        bus.inst_rdy_i     = 1'b0;
        test_reset();
        test_fetch_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_collide();
        test_wrap();
        test_reset_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
